mem_port_arbiter: RTL

- Shares one single-port synchronous unified memory between the instruction-fetch requester and the data (load/store) requester of the multicycle core.
- Holds one transaction in flight at a time: a request is accepted, issued to memory, and answered with a one-cycle response pulse to its requester.
- Grants round-robin on contention, so neither side starves.
- Sits between the fetch stage / core data path and the memory block.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/rr_grant2.sv | 33 +++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  typedef enum logic {REQ_IF, REQ_DM} req_id_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant; the remembered winner advances only on an accepted request.
module rr_grant2
  import mem_arb_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    req_if,
  input  logic    req_dm,
  input  logic    accept,
  output req_id_t grant
);

  req_id_t last_grant;

  always_comb begin
    grant = REQ_IF;
    if (req_if && req_dm) begin
      grant = (last_grant == REQ_IF) ? REQ_DM : REQ_IF;
    end else if (req_dm) begin
      grant = REQ_DM;
    end
  end

  // Reset to IF so the first contended grant goes to the data side.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_IF;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data accesses,
// one transaction in flight at a time, with a one-cycle response pulse per transaction.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_ADDR_W = 12,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_valid,
  input  logic [31:0]           if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_rsp_valid,
  output logic [31:0]           if_rsp_data,
  input  logic                  dm_req_valid,
  input  logic                  dm_req_we,
  input  logic [3:0]            dm_req_be,
  input  logic [31:0]           dm_req_addr,
  input  logic [31:0]           dm_req_wdata,
  output logic                  dm_req_ready,
  output logic                  dm_rsp_valid,
  output logic [31:0]           dm_rsp_data,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  busy
);

  if (RD_LAT == 0) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be at least 1");
  end

  localparam int unsigned OffW = $clog2(WORD_BYTES);
  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_t      state;
  req_id_t         owner;
  req_id_t         grant;
  logic            owner_we;
  logic [CntW-1:0] cnt;
  logic            can_accept;
  logic            accept;
  logic            unused_addr;

  // RESP behaves as idle for the handshake so back-to-back transactions lose no cycle.
  assign can_accept   = !reset && ((state == IDLE) || (state == RESP));
  assign if_req_ready = can_accept && (grant == REQ_IF);
  assign dm_req_ready = can_accept && (grant == REQ_DM);
  assign accept       = (if_req_valid && if_req_ready) || (dm_req_valid && dm_req_ready);
  assign busy         = (state != IDLE);
  assign unused_addr  = ^{if_req_addr, dm_req_addr};

  rr_grant2 u_rr_grant2 (
    .clk    (clk),
    .reset  (reset),
    .req_if (if_req_valid),
    .req_dm (dm_req_valid),
    .accept (accept),
    .grant  (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= REQ_IF;
      owner_we     <= 1'b0;
      cnt          <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 4'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'b0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= 32'b0;
      dm_rsp_valid <= 1'b0;
      dm_rsp_data  <= 32'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      dm_rsp_valid <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 4'b0;
      unique case (state)
        IDLE, RESP: begin
          if (accept) begin
            state  <= ISSUE;
            owner  <= grant;
            mem_en <= 1'b1;
            if (grant == REQ_DM) begin
              owner_we <= dm_req_we;
              mem_addr <= dm_req_addr[MEM_ADDR_W+OffW-1:OffW];
              if (dm_req_we) begin
                mem_we    <= dm_req_be;
                mem_wdata <= dm_req_wdata;
              end
            end else begin
              owner_we <= 1'b0;
              mem_addr <= if_req_addr[MEM_ADDR_W+OffW-1:OffW];
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (owner_we) begin
            state        <= RESP;
            dm_rsp_valid <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= CntW'(RD_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            if (owner == REQ_DM) begin
              dm_rsp_valid <= 1'b1;
              dm_rsp_data  <= mem_rdata;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
